// File: rtl/rect_engine.sv
// rect_engine
// -----------
// Register-programmed rectangle renderer for VGA-style pipelines. Holds
// N_RECT rectangles (position, size, colour, enable), tests the current
// pixel against each one, and drives the colour of the lowest-index hit as
// registered 4:4:4 RGB one pixel strobe after the coordinates are sampled.
//
// Optional feature, compiled in when the macro RECT_ANIM_EN is defined:
// per-rectangle signed velocities and a per-frame update FSM that steps
// every enabled rectangle and bounces it off the screen edges. Without the
// macro, velocity writes and i_frame are ignored, o_wr_rdy is tied high and
// o_busy/o_ovr are tied low.
//
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_pix_stb            pixel strobe; the render pipeline advances only on it
//   i_x, i_y             current pixel coordinates from the timing generator
//   i_frame              one-cycle frame-start pulse (vertical blanking)
//   i_wr_en/addr/data    register write port, addr = {rect index, field}
//   o_wr_rdy             write accepted when i_wr_en & o_wr_rdy
//   o_busy               animation update in progress
//   o_ovr                one-cycle pulse: i_frame arrived while busy
//   o_hit, o_rgb         registered hit flag and {R,G,B} colour

module rect_engine #(
    parameter int N_RECT = 6,
    parameter int XW     = 11,
    parameter int YW     = 10,
    parameter int H_RES  = 800,
    parameter int V_RES  = 600
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pix_stb,
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    input  logic          i_frame,
    input  logic          i_wr_en,
    input  logic [6:0]    i_wr_addr,
    input  logic [15:0]   i_wr_data,
    output logic          o_wr_rdy,
    output logic          o_busy,
    output logic          o_ovr,
    output logic          o_hit,
    output logic [11:0]   o_rgb
);

    localparam int IW = (N_RECT > 1) ? $clog2(N_RECT) : 1;

    logic [XW-1:0]   x0     [N_RECT];
    logic [YW-1:0]   y0     [N_RECT];
    logic [XW-1:0]   width  [N_RECT];
    logic [YW-1:0]   height [N_RECT];
    logic [11:0]     colour [N_RECT];
    logic [N_RECT-1:0] enable;

    logic [3:0]    wr_idx;
    logic [2:0]    wr_field;
    logic [IW-1:0] wr_sel;
    logic          wr_ok;

    logic          any_hit;
    logic [11:0]   pix_colour;

    assign wr_idx   = i_wr_addr[6:3];
    assign wr_field = i_wr_addr[2:0];
    assign wr_sel   = wr_idx[IW-1:0];
    // Indices beyond the populated rectangles must not alias onto real ones.
    assign wr_ok    = i_wr_en && o_wr_rdy && ({1'b0, wr_idx} < 5'(N_RECT));

`ifdef RECT_ANIM_EN
    typedef enum logic {IDLE, UPDATE} anim_state_t;

    anim_state_t   state, next_state;
    logic [IW-1:0] k;
    logic          ovr;
    logic [15:0]   vel [N_RECT];
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic [15:0]   nvel;
    int            dx, dy;

    // Next position on one axis; int arithmetic keeps the signed sum and the
    // far-edge comparison free of wrap for any legal coordinate width.
    function automatic int next_pos(input int pos, input int size,
                                    input int v, input int res);
        int n;
        n = pos + v;
        if (n < 0)
            return 0;
        else if (n + size > res)
            return (size > res) ? 0 : res - size;
        else
            return n;
    endfunction

    function automatic logic bounces(input int pos, input int size,
                                     input int v, input int res);
        int n;
        n = pos + v;
        return (n < 0) || (n + size > res);
    endfunction

    // -128 has no positive counterpart in 8 bits, so it reflects to +127.
    function automatic logic [7:0] neg_vel(input logic [7:0] v);
        return (v == 8'h80) ? 8'h7F : (~v + 8'd1);
    endfunction

    // State register, rectangle cursor and overrun flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            k     <= '0;
            ovr   <= 1'b0;
        end else begin
            state <= next_state;
            ovr   <= i_frame && (state == UPDATE);
            if (state == UPDATE)
                k <= (k == IW'(N_RECT - 1)) ? '0 : k + IW'(1);
        end
    end

    // A frame pulse starts a sweep only from IDLE; the sweep ends after the
    // last rectangle has been stepped.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (i_frame) next_state = UPDATE;
            UPDATE:  if (k == IW'(N_RECT - 1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Writes are held off for the whole sweep so they never race the update.
    always_comb begin
        o_busy   = (state == UPDATE);
        o_wr_rdy = (state == IDLE);
        o_ovr    = ovr;
    end

    // Bounce arithmetic for the rectangle currently under the cursor.
    always_comb begin
        dx = int'($signed(vel[k][7:0]));
        dy = int'($signed(vel[k][15:8]));
        nx = XW'(next_pos(int'(x0[k]), int'(width[k]), dx, H_RES));
        ny = YW'(next_pos(int'(y0[k]), int'(height[k]), dy, V_RES));
        nvel[7:0]  = bounces(int'(x0[k]), int'(width[k]), dx, H_RES)
                     ? neg_vel(vel[k][7:0]) : vel[k][7:0];
        nvel[15:8] = bounces(int'(y0[k]), int'(height[k]), dy, V_RES)
                     ? neg_vel(vel[k][15:8]) : vel[k][15:8];
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{i_frame, i_wr_data[15:12]};
    assign o_wr_rdy = 1'b1;
    assign o_busy   = 1'b0;
    assign o_ovr    = 1'b0;
`endif

    // Rectangle register file: host writes, plus the animation step when the
    // sweep reaches an enabled rectangle. The two never coincide because
    // o_wr_rdy is low during the sweep.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_RECT; i++) begin
                x0[i]     <= '0;
                y0[i]     <= '0;
                width[i]  <= '0;
                height[i] <= '0;
                colour[i] <= '0;
`ifdef RECT_ANIM_EN
                vel[i]    <= '0;
`endif
            end
            enable <= '0;
        end else begin
            if (wr_ok) begin
                case (wr_field)
                    3'd0: x0[wr_sel]     <= i_wr_data[XW-1:0];
                    3'd1: y0[wr_sel]     <= i_wr_data[YW-1:0];
                    3'd2: width[wr_sel]  <= i_wr_data[XW-1:0];
                    3'd3: height[wr_sel] <= i_wr_data[YW-1:0];
                    3'd4: colour[wr_sel] <= i_wr_data[11:0];
`ifdef RECT_ANIM_EN
                    3'd5: vel[wr_sel]    <= i_wr_data;
`endif
                    3'd6: enable[wr_sel] <= i_wr_data[0];
                    default: ;
                endcase
            end
`ifdef RECT_ANIM_EN
            if (state == UPDATE && enable[k]) begin
                x0[k]  <= nx;
                y0[k]  <= ny;
                vel[k] <= nvel;
            end
`endif
        end
    end

    // Hit test and priority: scanning from the highest index down lets the
    // lowest-index hit overwrite the others. Comparisons use one extra bit so
    // x0+width cannot wrap.
    always_comb begin
        any_hit    = 1'b0;
        pix_colour = '0;
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if (enable[i] &&
                ({1'b0, i_x} >= {1'b0, x0[i]}) &&
                ({1'b0, i_x} <  ({1'b0, x0[i]} + {1'b0, width[i]})) &&
                ({1'b0, i_y} >= {1'b0, y0[i]}) &&
                ({1'b0, i_y} <  ({1'b0, y0[i]} + {1'b0, height[i]}))) begin
                any_hit    = 1'b1;
                pix_colour = colour[i];
            end
        end
    end

    // Output register; holds its value between pixel strobes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_hit <= 1'b0;
            o_rgb <= '0;
        end else if (i_pix_stb) begin
            o_hit <= any_hit;
            o_rgb <= pix_colour;
        end
    end

endmodule

// File: tb/tb_rect_engine.sv
// tb_rect_engine
// --------------
// Directed, table-driven bench for rect_engine. Pixel probes are records of
// {x, y, strobe, expected hit, expected colour}; multi-cycle behaviour
// (frame sweep length, overrun pulse, held-off writes, reset mid-sweep) is
// exercised by hand-written sequences. Expectations depend on whether
// RECT_ANIM_EN is defined for the build.

module tb_rect_engine;

    localparam int N_RECT = 6;

`ifdef RECT_ANIM_EN
    localparam bit ANIM     = 1'b1;
    localparam int EXP_BUSY = N_RECT;
`else
    localparam bit ANIM     = 1'b0;
    localparam int EXP_BUSY = 0;
`endif

    typedef struct {
        int          x;
        int          y;
        logic        stb;
        logic        hit;
        logic [11:0] rgb;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_pix_stb = 1'b0;
    logic [10:0] i_x = '0;
    logic [9:0]  i_y = '0;
    logic        i_frame = 1'b0;
    logic        i_wr_en = 1'b0;
    logic [6:0]  i_wr_addr = '0;
    logic [15:0] i_wr_data = '0;
    logic        o_wr_rdy, o_busy, o_ovr, o_hit;
    logic [11:0] o_rgb;

    int tests = 0;
    int failures = 0;
    int last_wait = 0;
    int cnt;

    rect_engine #(.N_RECT(N_RECT), .XW(11), .YW(10), .H_RES(800), .V_RES(600)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb),
        .i_x(i_x), .i_y(i_y), .i_frame(i_frame),
        .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .o_wr_rdy(o_wr_rdy), .o_busy(o_busy), .o_ovr(o_ovr),
        .o_hit(o_hit), .o_rgb(o_rgb)
    );

    always #5 i_clk = ~i_clk;

    // Rect0 green square.
    vec_t square_vecs [8] = '{
        '{120, 20, 1'b1, 1'b1, 12'h0F0}, '{279, 20, 1'b1, 1'b1, 12'h0F0},
        '{280, 20, 1'b1, 1'b0, 12'h000}, '{119, 20, 1'b1, 1'b0, 12'h000},
        '{200, 179, 1'b1, 1'b1, 12'h0F0}, '{200, 180, 1'b1, 1'b0, 12'h000},
        '{200, 19, 1'b1, 1'b0, 12'h000}, '{279, 179, 1'b1, 1'b1, 12'h0F0}
    };

    // Rect0 red 150..249 x 50..149, rect1 blue 200..299 x 80..179.
    vec_t overlap_vecs [7] = '{
        '{200, 100, 1'b1, 1'b1, 12'hF00}, '{249, 149, 1'b1, 1'b1, 12'hF00},
        '{250, 100, 1'b1, 1'b1, 12'h00F}, '{160, 60, 1'b1, 1'b1, 12'hF00},
        '{299, 179, 1'b1, 1'b1, 12'h00F}, '{300, 100, 1'b1, 1'b0, 12'h000},
        '{199, 79, 1'b1, 1'b1, 12'hF00}
    };

    // Strobe pattern 1,0,0,1,0 repeated: an average of one strobe per 2.5 clocks.
    vec_t strobe_vecs [10] = '{
        '{200, 100, 1'b1, 1'b1, 12'hF00}, '{260, 100, 1'b0, 1'b1, 12'hF00},
        '{300, 100, 1'b0, 1'b1, 12'hF00}, '{260, 100, 1'b1, 1'b1, 12'h00F},
        '{200, 100, 1'b0, 1'b1, 12'h00F}, '{300, 100, 1'b1, 1'b0, 12'h000},
        '{200, 100, 1'b0, 1'b0, 12'h000}, '{200, 100, 1'b0, 1'b0, 12'h000},
        '{260, 100, 1'b1, 1'b1, 12'h00F}, '{300, 100, 1'b0, 1'b1, 12'h00F}
    };

    // Rect2 near the coordinate limits, rect3 zero width, rect4 zero height.
    vec_t corner_vecs [5] = '{
        '{2040, 1010, 1'b1, 1'b1, 12'hABC}, '{10, 1010, 1'b1, 1'b0, 12'h000},
        '{1999, 1010, 1'b1, 1'b0, 12'h000}, '{10, 10, 1'b1, 1'b0, 12'h000},
        '{410, 300, 1'b1, 1'b0, 12'h000}
    };

`ifdef RECT_ANIM_EN
    vec_t frame1_vecs [10] = '{
        '{790, 0, 1'b1, 1'b1, 12'hF00}, '{789, 0, 1'b1, 1'b0, 12'h000},
        '{799, 0, 1'b1, 1'b1, 12'hF00}, '{800, 0, 1'b1, 1'b0, 12'h000},
        '{0, 10, 1'b1, 1'b1, 12'h0F0},  '{10, 10, 1'b1, 1'b0, 12'h000},
        '{300, 590, 1'b1, 1'b1, 12'h00F}, '{300, 589, 1'b1, 1'b0, 12'h000},
        '{0, 200, 1'b1, 1'b1, 12'hAAA}, '{10, 200, 1'b1, 1'b0, 12'h000}
    };
    vec_t frame2_vecs [8] = '{
        '{787, 0, 1'b1, 1'b1, 12'hF00}, '{786, 0, 1'b1, 1'b0, 12'h000},
        '{4, 10, 1'b1, 1'b1, 12'h0F0},  '{3, 10, 1'b1, 1'b0, 12'h000},
        '{300, 587, 1'b1, 1'b1, 12'h00F}, '{300, 586, 1'b1, 1'b0, 12'h000},
        '{127, 200, 1'b1, 1'b1, 12'hAAA}, '{126, 200, 1'b1, 1'b0, 12'h000}
    };
`else
    // Without animation nothing moves on a frame pulse.
    vec_t frame1_vecs [8] = '{
        '{795, 0, 1'b1, 1'b1, 12'hF00}, '{790, 0, 1'b1, 1'b0, 12'h000},
        '{1, 10, 1'b1, 1'b1, 12'h0F0},  '{0, 10, 1'b1, 1'b0, 12'h000},
        '{300, 595, 1'b1, 1'b1, 12'h00F}, '{300, 590, 1'b1, 1'b0, 12'h000},
        '{100, 200, 1'b1, 1'b1, 12'hAAA}, '{99, 200, 1'b1, 1'b0, 12'h000}
    };
    vec_t frame2_vecs [8] = frame1_vecs;
`endif

    vec_t write_vecs [2] = '{
        '{100, 400, 1'b1, 1'b0, 12'h000}, '{500, 400, 1'b1, 1'b1, 12'hFFF}
    };

    // Drive one clock of pixel input; returns just after the active edge.
    task automatic applyStimulus(input int x, input int y, input logic stb);
        @(negedge i_clk);
        i_x = 11'(x);
        i_y = 10'(y);
        i_pix_stb = stb;
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic exp_hit, input logic [11:0] exp_rgb);
        tests++;
        if (o_hit !== exp_hit || o_rgb !== exp_rgb) begin
            failures++;
            $display("[TB] FAIL %s[%0d]: got hit=%0b rgb=%03h, expected hit=%0b rgb=%03h",
                     name, idx, o_hit, o_rgb, exp_hit, exp_rgb);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic runVec(input string name, input int idx, input vec_t v);
        applyStimulus(v.x, v.y, v.stb);
        checkOutput(name, idx, v.hit, v.rgb);
    endtask

    // Single write with handshake; counts the negedges spent waiting for ready.
    task automatic writeReg(input int idx, input int field, input logic [15:0] data);
        int n;
        @(negedge i_clk);
        i_wr_en   = 1'b1;
        i_wr_addr = {4'(idx), 3'(field)};
        i_wr_data = data;
        n = 0;
        while (!o_wr_rdy && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 100) begin
            failures++;
            $display("[TB] FAIL write timeout: o_wr_rdy low for %0d cycles, expected <100", n);
        end
        last_wait = n;
        @(posedge i_clk);
        #1 i_wr_en = 1'b0;
    endtask

    task automatic setRect(input int idx, input int x, input int y, input int w,
                           input int h, input int col, input logic en);
        writeReg(idx, 0, 16'(x));
        writeReg(idx, 1, 16'(y));
        writeReg(idx, 2, 16'(w));
        writeReg(idx, 3, 16'(h));
        writeReg(idx, 4, 16'(col));
        writeReg(idx, 6, {15'd0, en});
    endtask

    task automatic setVel(input int idx, input int dy, input int dx);
        writeReg(idx, 5, {8'(dy), 8'(dx)});
    endtask

    task automatic pulseFrame();
        @(negedge i_clk);
        i_frame = 1'b1;
        @(posedge i_clk);
        #1 i_frame = 1'b0;
    endtask

    // Counts busy clocks starting just after the frame edge.
    task automatic countBusy(output int n);
        n = 0;
        while (o_busy && n < 100) begin
            n++;
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic doReset();
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;

        // Reset state and empty-screen sweep.
        checkValue("reset wr_rdy", int'(o_wr_rdy), 1);
        checkValue("reset busy", int'(o_busy), 0);
        checkValue("reset ovr", int'(o_ovr), 0);
        checkOutput("reset out", 0, 1'b0, 12'h000);
        for (int y = 0; y < 600; y += 40)
            for (int x = 0; x < 800; x += 40) begin
                applyStimulus(x, y, 1'b1);
                checkOutput("empty sweep", y * 800 + x, 1'b0, 12'h000);
            end

        // Single square, exact edges.
        setRect(0, 120, 20, 160, 160, 12'h0F0, 1'b1);
        foreach (square_vecs[i]) runVec("square", i, square_vecs[i]);

        // Out-of-range index must not alias rect0.
        writeReg(8, 0, 16'd0);
        foreach (square_vecs[i]) runVec("alias", i, square_vecs[i]);

        // Priority between overlapping rectangles.
        setRect(0, 150, 50, 100, 100, 12'hF00, 1'b1);
        setRect(1, 200, 80, 100, 100, 12'h00F, 1'b1);
        foreach (overlap_vecs[i]) runVec("overlap", i, overlap_vecs[i]);
        foreach (strobe_vecs[i]) runVec("strobe", i, strobe_vecs[i]);
        writeReg(0, 6, 16'd0);
        runVec("disable r0", 0, '{200, 100, 1'b1, 1'b1, 12'h00F});
        runVec("disable r0", 1, '{160, 60, 1'b1, 1'b0, 12'h000});

        // Coordinate-limit and degenerate-size rectangles.
        writeReg(1, 6, 16'd0);
        setRect(2, 2000, 1000, 100, 50, 12'hABC, 1'b1);
        setRect(3, 10, 10, 0, 20, 12'hFFF, 1'b1);
        setRect(4, 400, 300, 20, 0, 12'h123, 1'b1);
        foreach (corner_vecs[i]) runVec("corner", i, corner_vecs[i]);

        // Frame animation and bounce.
        doReset();
        checkOutput("mid reset out", 0, 1'b0, 12'h000);
        setRect(0, 795, 0, 10, 1, 12'hF00, 1'b1);
        setVel(0, 0, 3);
        setRect(1, 1, 10, 10, 1, 12'h0F0, 1'b1);
        setVel(1, 0, -4);
        setRect(2, 300, 595, 10, 10, 12'h00F, 1'b1);
        setVel(2, 3, 0);
        setRect(3, 100, 200, 10, 1, 12'hAAA, 1'b1);
        setVel(3, 0, -128);
        setRect(5, 50, 50, 10, 10, 12'h555, 1'b0);
        setVel(5, 0, 100);
        pulseFrame();
        countBusy(cnt);
        checkValue("frame1 busy clocks", cnt, EXP_BUSY);
        checkValue("frame1 wr_rdy after", int'(o_wr_rdy), 1);
        foreach (frame1_vecs[i]) runVec("frame1", i, frame1_vecs[i]);
        runVec("disabled static", 0, '{50, 50, 1'b1, 1'b0, 12'h000});
        pulseFrame();
        countBusy(cnt);
        checkValue("frame2 busy clocks", cnt, EXP_BUSY);
        foreach (frame2_vecs[i]) runVec("frame2", i, frame2_vecs[i]);

        // Frame pulse during the sweep: overrun pulse, no restart.
        setRect(4, 100, 400, 10, 10, 12'hFFF, 1'b1);
        pulseFrame();
        cnt = int'(o_busy);
        @(negedge i_clk);
        i_frame = 1'b1;
        @(posedge i_clk);
        #1 i_frame = 1'b0;
        checkValue("ovr pulse", int'(o_ovr), int'(ANIM));
        cnt += int'(o_busy);
        @(posedge i_clk);
        #1;
        checkValue("ovr single cycle", int'(o_ovr), 0);
        for (int i = 0; i < 100 && o_busy; i++) begin
            cnt++;
            @(posedge i_clk);
            #1;
        end
        checkValue("ovr no restart busy clocks", cnt, EXP_BUSY);
        checkValue("ovr idle after", int'(o_busy), 0);

        // Write issued during the sweep is held off and lands afterwards.
        pulseFrame();
        writeReg(4, 0, 16'd500);
        checkValue("write held off", int'(last_wait > 0), int'(ANIM));
        foreach (write_vecs[i]) runVec("held write", i, write_vecs[i]);

        // Reset in the middle of a sweep.
        pulseFrame();
        @(posedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        checkValue("rst mid busy", int'(o_busy), 0);
        checkValue("rst mid wr_rdy", int'(o_wr_rdy), 1);
        checkOutput("rst mid out", 0, 1'b0, 12'h000);
        @(negedge i_clk);
        i_rst = 1'b0;
        runVec("rst cleared", 0, '{500, 400, 1'b1, 1'b0, 12'h000});
        runVec("rst cleared", 1, '{0, 200, 1'b1, 1'b0, 12'h000});
        pulseFrame();
        countBusy(cnt);
        checkValue("post-reset busy clocks", cnt, EXP_BUSY);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/rect_engine.md
# rect_engine

Parametrised rectangle renderer that replaces hard-coded square logic in top-level VGA designs. It sits between the `vga800x600`-style timing generator and the DAC pins. It holds N register-programmed rectangles with position, size, colour and enable, and composites them by fixed priority into registered 4:4:4 RGB. An optional per-frame animation engine moves each rectangle by a signed velocity and bounces it off the screen edges.

## Interface
- `N_RECT`, 6: number of rectangles, 1–16.
- `XW`, 11: x coordinate width.
- `YW`, 10: y coordinate width.
- `H_RES`, 800: active width, used for bounce.
- `V_RES`, 600: active height, used for bounce.
- `i_clk` input 1: system clock (100 MHz).
- `i_rst` input 1: reset, asynchronous and active-high.
- `i_pix_stb` input 1: pixel strobe; pipeline advances only when high.
- `i_x` input XW: current pixel x from timing generator.
- `i_y` input YW: current pixel y from timing generator.
- `i_frame` input 1: one-cycle frame-start pulse, issued in vertical blanking.
- `i_wr_en` input 1: register write request.
- `i_wr_addr` input 7: {rect index[6:3], field[2:0]}.
- `i_wr_data` input 16: write data.
- `o_wr_rdy` output 1: write accepted when `i_wr_en & o_wr_rdy`.
- `o_busy` output 1: animation update in progress.
- `o_ovr` output 1: one-cycle pulse when `i_frame` arrives while busy.
- `o_hit` output 1: registered; some enabled rectangle covers the pixel.
- `o_rgb` output 12: registered {R[3:0], G[3:0], B[3:0]}.

## Operation
- Fields:
  - 0 x0 [XW-1:0]
  - 1 y0 [YW-1:0]
  - 2 width [XW-1:0]
  - 3 height [YW-1:0]
  - 4 colour [11:0]
  - 5 velocity {dy[15:8], dx[7:0]}, signed
  - 6 enable [0]
  - 7: reserved; writes ignored.
- Writes with index ≥ N_RECT are ignored. An accepted write is visible to the hit logic on the next clock.
- Hit test for rect k:
  - Enabled, and `x0 ≤ i_x < x0+width` and `y0 ≤ i_y < y0+height`.
  - Sums are computed at XW+1 / YW+1 bits, so there is no wrap.
  - Width or height of 0 never hits.
- Priority: the lowest index wins. If no rectangle hits, `o_rgb`=0 and `o_hit`=0.
- Animation FSM:
  - IDLE → UPDATE on `i_frame` while IDLE.
  - UPDATE processes rect `k`=0..N_RECT-1, one per clock, then returns to IDLE.
  - Disabled rects are still stepped by k but are left unmodified.
- Per-axis update for enabled rects (x shown; y identical with V_RES):
  - `xn = x0 + sext(dx)`, signed XW+2 bits.
  - If `xn < 0`: x0←0, dx←−dx.
  - Else if `xn + width > H_RES`: x0←`H_RES−width` (0 if width > H_RES), dx←−dx.
  - Else x0←xn.
  - dx = −128 negates to +127 (saturate).
- While UPDATE, `o_wr_rdy`=0 and `o_busy`=1.
- Same-cycle `i_frame` and write while IDLE: the write is accepted; UPDATE starts next clock and uses the written value.
- `i_frame` during UPDATE is ignored and pulses `o_ovr`.
- Reset: all registers 0, all rects disabled, FSM IDLE. Outputs:
  - `o_rgb`=0, `o_hit`=0, `o_busy`=0, `o_ovr`=0
  - `o_wr_rdy`=1
- Reset asserted mid-UPDATE aborts immediately; after release the FSM is in IDLE with all registers 0.

## Timing
- Render latency is one pixel strobe: coordinates sampled on a clock with `i_pix_stb`=1 appear on `o_rgb`/`o_hit` after that edge. Outputs hold between strobes.
- Callers delay hsync/vsync by one strobe to align.
- UPDATE lasts exactly N_RECT clocks, from the clock after `i_frame` sampling. `o_busy` is high for those N_RECT clocks.
- Writes are single-cycle when `o_wr_rdy`=1. No backpressure beyond `o_wr_rdy`.

## Configuration
- `RECT_ANIM_EN` defined: velocity registers, FSM, bounce logic, `o_busy`/`o_ovr` are compiled in.
- `RECT_ANIM_EN` not defined:
  - Field-5 writes are ignored and `i_frame` is ignored.
  - `o_wr_rdy` tied 1; `o_busy` and `o_ovr` tied 0.
  - Geometry changes only via writes.

## Test plan
- Reset then no writes, sweep full 800x600 → `o_rgb`=0 and `o_hit`=0 everywhere; `o_wr_rdy`=1.
- Rect0 x0=120 y0=20 w=160 h=160 col=0x0F0, enabled → hit exactly for x 120..279, y 20..179. Pixel (279,20) gives 0x0F0; pixels (280,20) and (119,20) give 0.
- Rect0 red and rect1 blue, overlapping at (200,100) → 0xF00 (lower index wins). Disable rect0 → 0x00F.
- Overlap configuration, pixel strobe every 2.5 clocks → output changes one strobe after input and holds between strobes.
- With `RECT_ANIM_EN`: x0=795 w=10 dx=+3, pulse `i_frame` → x0=790, dx=−3, `o_busy` high N_RECT clocks. Also x0=1 dx=−4 → x0=0, dx=+4.
- With `RECT_ANIM_EN`, timing and reset corner cases:
  - `i_frame` during UPDATE → `o_ovr` one cycle, no restart.
  - Write during UPDATE is held off by `o_wr_rdy`=0 and lands after.
  - `i_rst` mid-UPDATE → all registers 0, IDLE.
